// File: rtl/memory_controller_pkg.sv
// Shared constants, types and helpers for the memory controller.
package memory_controller_pkg;

    // Width of the LSB slot tag that travels with each request.
    localparam int LSB_CAP_BIT = 4;

    // Access length encodings on lsb_len.
    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    // addr[17:16] value that selects the memory-mapped IO (UART) region.
    localparam logic [1:0] IO_REGION = 2'b11;

    // Instruction fetches are always one full word.
    localparam logic [2:0] FETCH_BYTES = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10
    } state_t;

    typedef enum logic {
        GRANT_LSB = 1'b0,
        GRANT_IF  = 1'b1
    } grant_t;

    // Number of RAM bytes touched for a given access length.
    function automatic logic [2:0] byte_count(input logic [1:0] len);
        case (len)
            LEN_BYTE: return 3'd1;
            LEN_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/memory_controller_if.sv
// Bus bundle between the memory controller and its surroundings
// (load/store buffer, instruction fetch and the byte-wide RAM).
//
// Handshake: a requester raises lsb_req / if_req with its fields stable and
// keeps them until the controller grants it (the controller leaves IDLE in the
// cycle after the grant). lsb_busy is a combinational hint that an LSB request
// in this cycle will not be taken. Completion is a one-cycle strobe
// (lsb_finished / if_done) carrying the result in the same cycle; there is no
// back-pressure on the strobes. The RAM returns mem_din one cycle after mem_a.
interface memory_controller_if;
    import memory_controller_pkg::*;

    logic                   lsb_req;
    logic [LSB_CAP_BIT-1:0] lsb_pos;
    logic                   lsb_ls;
    logic [1:0]             lsb_len;
    logic [31:0]            lsb_addr;
    logic [31:0]            lsb_val;
    logic                   lsb_busy;
    logic                   lsb_finished;
    logic [31:0]            lsb_res;
    logic [LSB_CAP_BIT-1:0] lsb_res_pos;

    logic                   if_req;
    logic [31:0]            if_addr;
    logic                   if_done;
    logic [31:0]            if_data;

    logic [7:0]             mem_din;
    logic [7:0]             mem_dout;
    logic [31:0]            mem_a;
    logic                   mem_wr;

    // Environment side: LSB, fetch unit and RAM.
    modport master (
        output lsb_req, lsb_pos, lsb_ls, lsb_len, lsb_addr, lsb_val,
        output if_req, if_addr, mem_din,
        input  lsb_busy, lsb_finished, lsb_res, lsb_res_pos,
        input  if_done, if_data, mem_dout, mem_a, mem_wr
    );

    // Controller side.
    modport slave (
        input  lsb_req, lsb_pos, lsb_ls, lsb_len, lsb_addr, lsb_val,
        input  if_req, if_addr, mem_din,
        output lsb_busy, lsb_finished, lsb_res, lsb_res_pos,
        output if_done, if_data, mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/memory_controller.sv
// Byte-serial memory controller arbitrating between the load/store buffer and
// instruction fetch. Each transfer moves 1, 2 or 4 little-endian bytes over an
// 8-bit RAM port with one cycle of read latency.
module memory_controller
    import memory_controller_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                clear,
    input  logic                io_buffer_full,
    memory_controller_if.slave  bus,
    output state_t              state_dbg
);

    state_t                 state_q;
    state_t                 state_d;
    grant_t                 last_grant_q;
    grant_t                 owner_q;
    logic [31:0]            addr_q;
    logic [31:0]            val_q;
    logic [31:0]            data_q;
    logic [2:0]             n_q;
    logic [2:0]             k_q;
    logic [LSB_CAP_BIT-1:0] pos_q;
    logic                   squash_q;

    logic                   busy;
    logic                   can_grant;
    logic                   grant_if;
    logic                   grant_lsb;
    logic                   io_stall;
    logic                   rd_issue;
    logic                   wr_issue;
    logic                   rd_last;
    logic                   wr_last;
    logic [31:0]            byte_addr;
    logic [1:0]             rd_idx;
    logic [31:0]            rd_word;

    // Busy whenever a transfer is active or fetch has priority this round.
    assign busy         = (state_q != ST_IDLE) || (bus.if_req && (last_grant_q == GRANT_LSB));
    assign bus.lsb_busy = busy;

    assign can_grant = (state_q == ST_IDLE) && rdy_in && !clear;
    assign grant_if  = can_grant && bus.if_req && (!bus.lsb_req || (last_grant_q == GRANT_LSB));
    assign grant_lsb = can_grant && !grant_if && bus.lsb_req && !busy;

    // UART writes wait while its buffer is full; the byte index does not move.
    assign io_stall  = (state_q == ST_WRITE) && (addr_q[17:16] == IO_REGION) && io_buffer_full;
    assign byte_addr = addr_q + {29'd0, k_q};

    // Reads issue bytes for k=0..n-1 and spend one extra cycle (k=n) catching
    // the last returned byte; writes complete in exactly n issue cycles.
    assign rd_issue = (state_q == ST_READ) && (k_q < n_q);
    assign wr_issue = (state_q == ST_WRITE) && !io_stall;
    assign rd_last  = (state_q == ST_READ) && (k_q == n_q);
    assign wr_last  = wr_issue && (k_q == (n_q - 3'd1));

    // The byte on mem_din belongs to the address issued one cycle earlier.
    assign rd_idx = k_q[1:0] - 2'd1;

    // Current assembly word with the byte arriving this cycle merged in.
    always_comb begin
        rd_word = data_q;
        if (k_q != 3'd0) begin
            rd_word[{rd_idx, 3'b000} +: 8] = bus.mem_din;
        end
    end

    // RAM port drive; everything parks at zero when no byte is issued.
    always_comb begin
        bus.mem_a    = 32'd0;
        bus.mem_dout = 8'd0;
        bus.mem_wr   = 1'b0;
        if (rd_issue) begin
            bus.mem_a = byte_addr;
        end else if (wr_issue) begin
            bus.mem_a    = byte_addr;
            bus.mem_dout = val_q[{k_q[1:0], 3'b000} +: 8];
            bus.mem_wr   = rdy_in;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_if) begin
                    state_d = ST_READ;
                end else if (grant_lsb) begin
                    state_d = bus.lsb_ls ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                if (clear || rd_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (wr_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; a low rdy_in holds the machine where it is.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    // Request latching, byte counting, data assembly and completion strobes.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_grant_q     <= GRANT_LSB;
            owner_q          <= GRANT_LSB;
            addr_q           <= 32'd0;
            val_q            <= 32'd0;
            data_q           <= 32'd0;
            n_q              <= 3'd0;
            k_q              <= 3'd0;
            pos_q            <= '0;
            squash_q         <= 1'b0;
            bus.lsb_finished <= 1'b0;
            bus.lsb_res      <= 32'd0;
            bus.lsb_res_pos  <= '0;
            bus.if_done      <= 1'b0;
            bus.if_data      <= 32'd0;
        end else if (rdy_in) begin
            bus.lsb_finished <= 1'b0;
            bus.if_done      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    k_q      <= 3'd0;
                    data_q   <= 32'd0;
                    squash_q <= 1'b0;
                    if (grant_if) begin
                        last_grant_q <= GRANT_IF;
                        owner_q      <= GRANT_IF;
                        addr_q       <= bus.if_addr;
                        n_q          <= FETCH_BYTES;
                    end else if (grant_lsb) begin
                        last_grant_q <= GRANT_LSB;
                        owner_q      <= GRANT_LSB;
                        addr_q       <= bus.lsb_addr;
                        val_q        <= bus.lsb_val;
                        n_q          <= byte_count(bus.lsb_len);
                        pos_q        <= bus.lsb_pos;
                    end
                end
                ST_READ: begin
                    if (clear) begin
                        k_q <= 3'd0;
                    end else begin
                        data_q <= rd_word;
                        if (rd_last) begin
                            k_q <= 3'd0;
                            if (owner_q == GRANT_IF) begin
                                bus.if_done <= 1'b1;
                                bus.if_data <= rd_word;
                            end else begin
                                bus.lsb_finished <= 1'b1;
                                bus.lsb_res      <= rd_word;
                                bus.lsb_res_pos  <= pos_q;
                            end
                        end else begin
                            k_q <= k_q + 3'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    // A flushed store still reaches memory but is not reported.
                    if (clear) begin
                        squash_q <= 1'b1;
                    end
                    if (wr_issue) begin
                        if (wr_last) begin
                            k_q              <= 3'd0;
                            bus.lsb_finished <= !(squash_q || clear);
                        end else begin
                            k_q <= k_q + 3'd1;
                        end
                    end
                end
                default: k_q <= 3'd0;
            endcase
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: a table of single transactions plus
// hand-written sequences for arbitration, IO stall, flush, pause and reset.
module tb_memory_controller;
    import memory_controller_pkg::*;

    logic   clk_in = 1'b0;
    logic   rst_in;
    logic   rdy_in;
    logic   clear;
    logic   io_buffer_full;
    state_t state_dbg;

    memory_controller_if bus();

    memory_controller dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .clear          (clear),
        .io_buffer_full (io_buffer_full),
        .bus            (bus.slave),
        .state_dbg      (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk_in = ~clk_in;

    // ---------------- RAM model and write monitor ----------------
    typedef struct packed {
        logic [31:0] cycle;
        logic [31:0] a;
        logic [7:0]  d;
    } wr_rec_t;

    logic [7:0]  ram [int unsigned];
    logic [31:0] cyc = 32'd0;
    wr_rec_t     wlog[$];
    logic [39:0] exp_q[$];

    always @(posedge clk_in) begin
        if (ram.exists(bus.mem_a)) bus.mem_din <= ram[bus.mem_a];
        else                       bus.mem_din <= 8'h00;
        if (bus.mem_wr) wlog.push_back('{cycle: cyc, a: bus.mem_a, d: bus.mem_dout});
        cyc <= cyc + 32'd1;
    end

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        bus.lsb_req    = 1'b0;
        bus.lsb_pos    = '0;
        bus.lsb_ls     = 1'b0;
        bus.lsb_len    = 2'b00;
        bus.lsb_addr   = 32'd0;
        bus.lsb_val    = 32'd0;
        bus.if_req     = 1'b0;
        bus.if_addr    = 32'd0;
        clear          = 1'b0;
        io_buffer_full = 1'b0;
        rdy_in         = 1'b1;
    endtask

    task automatic drive_lsb(input logic ls, input logic [1:0] len, input logic [31:0] addr,
                             input logic [31:0] val, input logic [LSB_CAP_BIT-1:0] pos);
        bus.lsb_req  = 1'b1;
        bus.lsb_ls   = ls;
        bus.lsb_len  = len;
        bus.lsb_addr = addr;
        bus.lsb_val  = val;
        bus.lsb_pos  = pos;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_in = 1'b1;
        step();
        step();
        #1;
        check("rst_state",    state_dbg, ST_IDLE);
        check("rst_mem_wr",   bus.mem_wr, 1'b0);
        check("rst_mem_a",    bus.mem_a, 32'd0);
        check("rst_finished", bus.lsb_finished, 1'b0);
        check("rst_if_done",  bus.if_done, 1'b0);
        check("rst_lsb_res",  bus.lsb_res, 32'd0);
        check("rst_res_pos",  bus.lsb_res_pos, 4'd0);
        check("rst_if_data",  bus.if_data, 32'd0);
        check("rst_lsb_busy", bus.lsb_busy, 1'b0);
        rst_in = 1'b0;
    endtask

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    // ---------------- vector table ----------------
    // kind: 0 = load, 1 = store, 2 = fetch. exp_lat is the pulse cycle relative to grant.
    typedef struct {
        int                     kind;
        logic [1:0]             len;
        logic [31:0]            addr;
        logic [31:0]            val;
        logic [LSB_CAP_BIT-1:0] pos;
        logic [31:0]            exp_data;
        int                     exp_lat;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    initial begin
        int          t0;
        int          wbase;
        int          got_lat;
        int          pulses;
        int          both;
        int          nb;
        int          cnt_a;
        int          cnt_b;
        logic        got_port;
        logic [31:0] got_data;
        logic [3:0]  got_pos;
        state_t      got_state;
        wr_rec_t     rec;
        int          order[$];

        // RAM contents
        ram[32'h1000] = 8'h11; ram[32'h1001] = 8'h22; ram[32'h1002] = 8'h33; ram[32'h1003] = 8'h44;
        ram[32'h0400] = 8'h93; ram[32'h0401] = 8'h00; ram[32'h0402] = 8'h10; ram[32'h0403] = 8'h00;

        vecs[0] = '{kind: 0, len: 2'b10, addr: 32'h1000, val: 32'h0,        pos: 4'd5, exp_data: 32'h44332211, exp_lat: 6};
        vecs[1] = '{kind: 0, len: 2'b01, addr: 32'h1002, val: 32'h0,        pos: 4'd9, exp_data: 32'h00004433, exp_lat: 4};
        vecs[2] = '{kind: 0, len: 2'b00, addr: 32'h1001, val: 32'h0,        pos: 4'd2, exp_data: 32'h00000022, exp_lat: 3};
        vecs[3] = '{kind: 1, len: 2'b01, addr: 32'h2002, val: 32'h0000BEEF, pos: 4'd1, exp_data: 32'h0,        exp_lat: 3};
        vecs[4] = '{kind: 1, len: 2'b10, addr: 32'h2010, val: 32'hDEADBEEF, pos: 4'd3, exp_data: 32'h0,        exp_lat: 5};
        vecs[5] = '{kind: 1, len: 2'b00, addr: 32'h30000, val: 32'h00000041, pos: 4'd4, exp_data: 32'h0,       exp_lat: 2};
        vecs[6] = '{kind: 2, len: 2'b10, addr: 32'h0400, val: 32'h0,        pos: 4'd0, exp_data: 32'h00100093, exp_lat: 6};
        vecs[7] = '{kind: 0, len: 2'b00, addr: 32'h1003, val: 32'h0,        pos: 4'd15, exp_data: 32'h00000044, exp_lat: 3};
        vecs[8] = '{kind: 2, len: 2'b10, addr: 32'h1000, val: 32'h0,        pos: 4'd0, exp_data: 32'h44332211, exp_lat: 6};

        idle_inputs();
        rst_in = 1'b1;
        bus.mem_din = 8'h00;
        do_reset();

        // ---- table-driven single transactions ----
        for (int i = 0; i < NV; i++) begin
            step();
            t0 = int'(cyc);
            if (vecs[i].kind == 2) begin
                bus.if_req  = 1'b1;
                bus.if_addr = vecs[i].addr;
            end else begin
                drive_lsb(vecs[i].kind == 1, vecs[i].len, vecs[i].addr, vecs[i].val, vecs[i].pos);
            end
            wbase = wlog.size();
            nb = (vecs[i].kind == 2) ? 4 : nbytes(vecs[i].len);
            if (vecs[i].kind == 1)
                for (int k = 0; k < nb; k++)
                    exp_q.push_back({vecs[i].addr + 32'(k), vecs[i].val[8*k +: 8]});
            got_lat = -1; pulses = 0; both = 0;
            got_port = 1'b0; got_data = 32'd0; got_pos = 4'd0; got_state = ST_IDLE;
            for (int c = 1; c <= vecs[i].exp_lat + 3; c++) begin
                step();
                bus.lsb_req = 1'b0;
                bus.if_req  = 1'b0;
                #1;
                if (bus.lsb_finished && bus.if_done) both++;
                if (bus.lsb_finished || bus.if_done) begin
                    pulses++;
                    if (got_lat < 0) begin
                        got_lat   = c;
                        got_port  = bus.if_done;
                        got_data  = bus.if_done ? bus.if_data : bus.lsb_res;
                        got_pos   = bus.lsb_res_pos;
                        got_state = state_dbg;
                    end
                end
            end
            check($sformatf("v%0d_latency", i), got_lat, vecs[i].exp_lat);
            check($sformatf("v%0d_pulses", i), pulses, 1);
            check($sformatf("v%0d_overlap", i), both, 0);
            check($sformatf("v%0d_port", i), got_port, vecs[i].kind == 2);
            check($sformatf("v%0d_idle_at_done", i), got_state, ST_IDLE);
            if (vecs[i].kind != 1) check($sformatf("v%0d_data", i), got_data, vecs[i].exp_data);
            if (vecs[i].kind == 0) check($sformatf("v%0d_res_pos", i), got_pos, vecs[i].pos);
            check($sformatf("v%0d_wr_count", i), wlog.size() - wbase, (vecs[i].kind == 1) ? nb : 0);
            if (vecs[i].kind == 1) begin
                for (int k = 0; k < nb && (wbase + k) < wlog.size(); k++) begin
                    rec = wlog[wbase + k];
                    check($sformatf("v%0d_wr%0d_byte", i, k), {rec.a, rec.d}, exp_q.pop_front());
                    check($sformatf("v%0d_wr%0d_cycle", i, k), rec.cycle, t0 + 1 + k);
                end
            end
            exp_q.delete();
        end

        // ---- round-robin with both requesters held from reset ----
        do_reset();
        step();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0400;
        drive_lsb(1'b0, 2'b10, 32'h1000, 32'h0, 4'd7);
        #1;
        check("rr_busy_first", bus.lsb_busy, 1'b1);
        for (int c = 0; c < 80 && order.size() < 4; c++) begin
            step();
            #1;
            if (bus.if_done) begin
                order.push_back(1);
                check("rr_fetch_data", bus.if_data, 32'h00100093);
                check("rr_busy_after_fetch", bus.lsb_busy, 1'b0);
            end else if (bus.lsb_finished) begin
                order.push_back(0);
                check("rr_lsb_data", bus.lsb_res, 32'h44332211);
                check("rr_busy_fetch_next", bus.lsb_busy, 1'b1);
            end
        end
        check("rr_grant_count", order.size(), 4);
        for (int g = 0; g < order.size(); g++)
            check($sformatf("rr_grant%0d", g), order[g], (g % 2 == 0) ? 1 : 0);
        idle_inputs();
        for (int c = 0; c < 10; c++) step();

        // ---- UART store stalled by a full buffer for three cycles ----
        step();
        drive_lsb(1'b1, 2'b00, 32'h00030000, 32'h00000041, 4'd6);
        io_buffer_full = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            bus.lsb_req = 1'b0;
            #1;
            check($sformatf("io_stall%0d_wr", c), bus.mem_wr, 1'b0);
            check($sformatf("io_stall%0d_a", c), bus.mem_a, 32'd0);
        end
        step();
        io_buffer_full = 1'b0;
        #1;
        check("io_release_wr", bus.mem_wr, 1'b1);
        check("io_release_a", bus.mem_a, 32'h00030000);
        check("io_release_d", bus.mem_dout, 8'h41);
        step();
        #1;
        check("io_finished", bus.lsb_finished, 1'b1);
        step();
        #1;
        check("io_finished_once", bus.lsb_finished, 1'b0);

        // ---- flush in T+2 of a fetch ----
        step();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0400;
        cnt_a = 0; cnt_b = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            bus.if_req  = 1'b0;
            bus.lsb_req = 1'b0;
            clear = (c == 2);
            if (c == 4) drive_lsb(1'b0, 2'b00, 32'h1001, 32'h0, 4'd8);
            #1;
            if (bus.if_done) cnt_a++;
            if (c == 3) check("flush_idle_t3", state_dbg, ST_IDLE);
            if (c == 5) check("flush_regrant_t4", state_dbg, ST_READ);
            if (c == 7) begin
                check("flush_next_finished", bus.lsb_finished, 1'b1);
                check("flush_next_data", bus.lsb_res, 32'h00000022);
            end
        end
        check("flush_no_if_done", cnt_a, 0);
        idle_inputs();

        // ---- flush during a word store: bytes still written, no finish ----
        step();
        drive_lsb(1'b1, 2'b10, 32'h2020, 32'hCAFEF00D, 4'd10);
        cnt_a = 0; cnt_b = 0;
        for (int c = 1; c <= 8; c++) begin
            step();
            bus.lsb_req = 1'b0;
            clear = (c == 2);
            #1;
            if (bus.mem_wr) cnt_a++;
            if (bus.lsb_finished) cnt_b++;
            if (c == 5) check("wflush_idle", state_dbg, ST_IDLE);
        end
        check("wflush_wr_cycles", cnt_a, 4);
        check("wflush_no_finished", cnt_b, 0);
        idle_inputs();

        // ---- pause: no grant while rdy_in low, store held mid-transfer ----
        step();
        drive_lsb(1'b1, 2'b01, 32'h2002, 32'h0000BEEF, 4'd11);
        rdy_in = 1'b0;
        step();
        rdy_in = 1'b1;
        #1;
        check("pause_no_grant", state_dbg, ST_IDLE);
        for (int c = 1; c <= 2; c++) begin
            step();
            bus.lsb_req = 1'b0;
            rdy_in = 1'b0;
            #1;
            check($sformatf("pause%0d_wr", c), bus.mem_wr, 1'b0);
        end
        step();
        rdy_in = 1'b1;
        #1;
        check("pause_wr0", {bus.mem_wr, bus.mem_a, bus.mem_dout}, {1'b1, 32'h2002, 8'hEF});
        step();
        #1;
        check("pause_wr1", {bus.mem_wr, bus.mem_a, bus.mem_dout}, {1'b1, 32'h2003, 8'hBE});
        step();
        #1;
        check("pause_finished", bus.lsb_finished, 1'b1);

        // ---- reset in the middle of a word store ----
        step();
        drive_lsb(1'b1, 2'b10, 32'h2030, 32'h12345678, 4'd12);
        step();
        bus.lsb_req = 1'b0;
        #1;
        check("rstmid_wr_before", bus.mem_wr, 1'b1);
        step();
        rst_in = 1'b1;
        step();
        #1;
        check("rstmid_wr", bus.mem_wr, 1'b0);
        check("rstmid_a", bus.mem_a, 32'd0);
        check("rstmid_state", state_dbg, ST_IDLE);
        check("rstmid_outputs", {bus.lsb_finished, bus.if_done, bus.lsb_res, bus.if_data, bus.lsb_res_pos},
              {1'b0, 1'b0, 32'd0, 32'd0, 4'd0});
        rst_in = 1'b0;
        cnt_a = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            #1;
            if (bus.mem_wr || bus.lsb_finished) cnt_a++;
        end
        check("rstmid_quiet_after", cnt_a, 0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
